// File: rtl/cnn_pkg.sv
// Shared pooling-mode encoding, XLEN-derived parameter defaults and
// helpers for the derived accumulator widths of the pooling datapath.
package cnn_pkg;

    localparam int CNN_XLEN         = 16;
    localparam int CNN_DATA_WID_DEF = CNN_XLEN;
    localparam int CNN_OCP_NUM_DEF  = CNN_XLEN / 4;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // Right shift that turns a KxK window sum into its floored mean.
    function automatic int pool_shift(input int pool_k);
        return 2 * $clog2(pool_k);
    endfunction

    function automatic int pool_sum_wid(input int data_wid, input int pool_k);
        return data_wid + pool_shift(pool_k);
    endfunction

endpackage

// File: rtl/pool_acc.sv
// One channel of the pooling datapath: per-window partial buffer plus
// load / signed-max / accumulate. Average logic exists only with CNN_POOL_AVG_EN.
module pool_acc
    import cnn_pkg::*;
#(
    parameter int DATA_WID = CNN_DATA_WID_DEF,
    parameter int POOL_K   = 2,
    parameter int ENTRIES  = 4,
    parameter int IDX_W    = 2
) (
    input  logic                clk,
    input  logic                en,
    input  logic [IDX_W-1:0]    idx,
    input  logic                first,
    input  logic                avg,
    input  logic [DATA_WID-1:0] sample,
    output logic [DATA_WID-1:0] result
);

`ifdef CNN_POOL_AVG_EN
    localparam int ACC_W = pool_sum_wid(DATA_WID, POOL_K);
    localparam int SHIFT = pool_shift(POOL_K);
`else
    localparam int ACC_W = DATA_WID;
`endif

    logic signed [ACC_W-1:0] mem_q [ENTRIES];
    logic signed [ACC_W-1:0] cur_s;
    logic signed [ACC_W-1:0] smp_s;
    logic signed [ACC_W-1:0] acc_d;

    assign cur_s = mem_q[idx];
    assign smp_s = ACC_W'($signed(sample));

    // Next partial value for the addressed window entry.
    always_comb begin
        acc_d = smp_s;
        if (first) begin
            acc_d = smp_s;
`ifdef CNN_POOL_AVG_EN
        end else if (avg) begin
            acc_d = cur_s + smp_s;
`endif
        end else if (smp_s > cur_s) begin
            acc_d = smp_s;
        end else begin
            acc_d = cur_s;
        end
    end

`ifdef CNN_POOL_AVG_EN
    // Arithmetic shift floors toward -inf, matching the mean definition.
    assign result = avg ? DATA_WID'(acc_d >>> SHIFT) : DATA_WID'(acc_d);
`else
    logic avg_unused_s;
    assign avg_unused_s = avg;
    assign result       = DATA_WID'(acc_d);
`endif

    // Partial buffer write; stale contents are always overwritten by a window's first pixel.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[idx] <= acc_d;
        end
    end

endmodule

// File: rtl/cnn_pool_relu_stream.sv
// Streaming KxK max/average pooling with optional ReLU over OCP_NUM channels.
// Average pooling is built only when CNN_POOL_AVG_EN is defined.
module cnn_pool_relu_stream
    import cnn_pkg::*;
#(
    parameter int DATA_WID = CNN_DATA_WID_DEF,
    parameter int OCP_NUM  = CNN_OCP_NUM_DEF,
    parameter int POOL_K   = 2,
    parameter int FMAP_W   = 8,
    parameter int FMAP_H   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sof,
    input  logic [OCP_NUM*DATA_WID-1:0] in_data,
    input  logic                        pool_mode,
    input  logic                        relu_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OCP_NUM*DATA_WID-1:0] out_data,
    output logic                        out_last,
    output logic                        frame_err
);

    localparam int KB      = $clog2(POOL_K);
    localparam int COL_W   = $clog2(FMAP_W);
    localparam int ROW_W   = $clog2(FMAP_H);
    localparam int ENTRIES = FMAP_W / POOL_K;
    localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int VEC_W   = OCP_NUM * DATA_WID;

    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(FMAP_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(FMAP_H - 1);
    localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
    localparam logic [KB-1:0]    SUB_MAX  = KB'(POOL_K - 1);
    localparam logic [KB-1:0]    SUB_ZERO = {KB{1'b0}};

    logic [COL_W-1:0] col_q, col_d, eff_col_s;
    logic [ROW_W-1:0] row_q, row_d, eff_row_s;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_err_q, frame_err_d;
    logic [VEC_W-1:0] out_data_q, out_data_d;
    pool_mode_e       mode_q, mode_d, req_mode_s, eff_mode_s;
    logic             relu_q, relu_d, eff_relu_s;

    logic             in_fire_s, mid_s, first_s, last_s, avg_sel_s;
    logic [IDX_W-1:0] idx_s;
    logic [VEC_W-1:0] res_s, act_s;

`ifdef CNN_POOL_AVG_EN
    assign req_mode_s = pool_mode_e'(pool_mode);
`else
    logic pool_mode_unused_s;
    assign pool_mode_unused_s = pool_mode;
    assign req_mode_s         = POOL_MAX;
`endif

    assign in_ready  = !out_valid_q || out_ready;
    assign in_fire_s = in_valid && in_ready;
    assign mid_s     = (col_q != COL_ZERO) || (row_q != ROW_ZERO);

    // A start-of-frame pixel restarts the frame at (0,0) with freshly sampled mode.
    always_comb begin
        if (in_sof) begin
            eff_col_s  = COL_ZERO;
            eff_row_s  = ROW_ZERO;
            eff_mode_s = req_mode_s;
            eff_relu_s = relu_en;
        end else begin
            eff_col_s  = col_q;
            eff_row_s  = row_q;
            eff_mode_s = mode_q;
            eff_relu_s = relu_q;
        end
    end

    assign first_s   = (eff_row_s[KB-1:0] == SUB_ZERO) && (eff_col_s[KB-1:0] == SUB_ZERO);
    assign last_s    = (eff_row_s[KB-1:0] == SUB_MAX) && (eff_col_s[KB-1:0] == SUB_MAX);
    assign idx_s     = IDX_W'(eff_col_s >> KB);
    assign avg_sel_s = (eff_mode_s == POOL_AVG);

    for (genvar g = 0; g < OCP_NUM; g++) begin : g_ch
        pool_acc #(
            .DATA_WID (DATA_WID),
            .POOL_K   (POOL_K),
            .ENTRIES  (ENTRIES),
            .IDX_W    (IDX_W)
        ) u_acc (
            .clk    (clk),
            .en     (in_fire_s),
            .idx    (idx_s),
            .first  (first_s),
            .avg    (avg_sel_s),
            .sample (in_data[g*DATA_WID +: DATA_WID]),
            .result (res_s[g*DATA_WID +: DATA_WID])
        );
    end

    // ReLU on the completed window values.
    always_comb begin
        act_s = res_s;
        for (int c = 0; c < OCP_NUM; c++) begin
            if (eff_relu_s && res_s[c*DATA_WID + DATA_WID - 1]) begin
                act_s[c*DATA_WID +: DATA_WID] = {DATA_WID{1'b0}};
            end else begin
                act_s[c*DATA_WID +: DATA_WID] = res_s[c*DATA_WID +: DATA_WID];
            end
        end
    end

    // Counters, latched mode, error flag and the output holding register.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        frame_err_d = frame_err_q;
        mode_d      = mode_q;
        relu_d      = relu_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (in_fire_s) begin
            if (in_sof) begin
                mode_d      = req_mode_s;
                relu_d      = relu_en;
                frame_err_d = frame_err_q || mid_s;
            end else begin
                mode_d = mode_q;
            end
            if (eff_col_s == COL_MAX) begin
                col_d = COL_ZERO;
                if (eff_row_s == ROW_MAX) begin
                    row_d = ROW_ZERO;
                end else begin
                    row_d = eff_row_s + ROW_W'(1);
                end
            end else begin
                col_d = eff_col_s + COL_W'(1);
                row_d = eff_row_s;
            end
            if (last_s) begin
                out_valid_d = 1'b1;
                out_last_d  = (eff_row_s == ROW_MAX) && (eff_col_s == COL_MAX);
                out_data_d  = act_s;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            col_d = col_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= COL_ZERO;
            row_q       <= ROW_ZERO;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {VEC_W{1'b0}};
            frame_err_q <= 1'b0;
            mode_q      <= POOL_MAX;
            relu_q      <= 1'b1;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            frame_err_q <= frame_err_d;
            mode_q      <= mode_d;
            relu_q      <= relu_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cnn_pool_relu_stream.sv
// Self-checking bench for cnn_pool_relu_stream on a 4x4 map, K=2, with a
// window-level reference model; expectations follow CNN_POOL_AVG_EN if defined.
module tb_cnn_pool_relu_stream;

    localparam int DW  = 16;
    localparam int OCP = 4;
    localparam int K   = 2;
    localparam int FW  = 4;
    localparam int FH  = 4;
    localparam int VW  = OCP * DW;
`ifdef CNN_POOL_AVG_EN
    localparam bit AVG_BUILT = 1'b1;
`else
    localparam bit AVG_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          pool_mode = 1'b0;
    logic          relu_en = 1'b1;
    logic          out_ready = 1'b1;
    logic [VW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_last, frame_err;
    logic [VW-1:0] out_data;

    cnn_pool_relu_stream #(
        .DATA_WID (DW), .OCP_NUM (OCP), .POOL_K (K), .FMAP_W (FW), .FMAP_H (FH)
    ) dut (
        .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready),
        .in_sof (in_sof), .in_data (in_data), .pool_mode (pool_mode),
        .relu_en (relu_en), .out_valid (out_valid), .out_ready (out_ready),
        .out_data (out_data), .out_last (out_last), .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(input bit ok, input string nm, input logic [VW-1:0] act,
                                input logic [VW-1:0] req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // Reference model: pixel store indexed by frame position, windows evaluated when complete.
    typedef struct { logic [VW-1:0] data; logic last; } exp_t;
    int   pix [FH][FW][OCP];
    int   m_row = 0, m_col = 0;
    bit   m_avg = 1'b0, m_relu = 1'b1, m_err = 1'b0;
    exp_t exp_q[$];
    int   obs_v[$];
    bit   obs_l[$];
    int   rdy_mode = 0;
    int   fv[FH*FW];
    int   ev[4];

    function automatic void model_accept();
        exp_t e;
        int   s, v;
        logic signed [DW-1:0] sv;
        if (in_sof) begin
            if (m_row != 0 || m_col != 0) m_err = 1'b1;
            m_row  = 0;
            m_col  = 0;
            m_avg  = AVG_BUILT && pool_mode;
            m_relu = relu_en;
        end
        for (int c = 0; c < OCP; c++) begin
            sv = in_data[c*DW +: DW];
            pix[m_row][m_col][c] = int'(sv);
        end
        if ((m_row % K == K-1) && (m_col % K == K-1)) begin
            for (int c = 0; c < OCP; c++) begin
                s = 0;
                v = pix[m_row-K+1][m_col-K+1][c];
                for (int r = m_row-K+1; r <= m_row; r++)
                    for (int q = m_col-K+1; q <= m_col; q++) begin
                        s += pix[r][q][c];
                        if (pix[r][q][c] > v) v = pix[r][q][c];
                    end
                if (m_avg) begin
                    v = s / (K*K);
                    if (s < 0 && (s % (K*K)) != 0) v = v - 1;
                end
                if (m_relu && v < 0) v = 0;
                e.data[c*DW +: DW] = v[DW-1:0];
            end
            e.last = (m_row == FH-1) && (m_col == FW-1);
            exp_q.push_back(e);
        end
        m_col++;
        if (m_col == FW) begin
            m_col = 0;
            m_row++;
            if (m_row == FH) m_row = 0;
        end
    endfunction

    // Compare process: outputs sampled on the falling edge every cycle.
    always @(negedge clk) begin
        logic signed [DW-1:0] o0;
        if (reset) begin
            exp_q.delete();
            m_row = 0; m_col = 0; m_avg = 1'b0; m_relu = 1'b1; m_err = 1'b0;
        end else begin
            chk(in_ready === (!out_valid || out_ready), "in_ready_rule", VW'(in_ready),
                VW'(!out_valid || out_ready));
            chk(frame_err === m_err, "frame_err", VW'(frame_err), VW'(m_err));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_result", out_data, '0);
                end else begin
                    chk(out_data === exp_q[0].data, "out_data", out_data, exp_q[0].data);
                    chk(out_last === exp_q[0].last, "out_last", VW'(out_last), VW'(exp_q[0].last));
                    if (out_ready) begin
                        o0 = out_data[DW-1:0];
                        obs_v.push_back(int'(o0));
                        obs_l.push_back(out_last);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) model_accept();
        end
    end

    // Consumer back-pressure pattern.
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] d;
        logic [31:0]   r;
        int            x;
        for (int c = 0; c < OCP; c++) begin
            r = $urandom;
            x = int'($urandom_range(0, 120)) - 60;
            if ($urandom_range(0, 7) == 0) d[c*DW +: DW] = r[DW-1:0];
            else d[c*DW +: DW] = x[DW-1:0];
        end
        return d;
    endfunction

    task automatic send_px(input logic [VW-1:0] d, input logic sof, input logic mode,
                           input logic relu);
        int waited = 0;
        in_data = d; in_sof = sof; pool_mode = mode; relu_en = relu; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) chk(1'b0, "in_ready_timeout", VW'(in_ready), VW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0;
        pool_mode = 1'($urandom); relu_en = 1'($urandom);
    endtask

    task automatic send_frame(input bit sof0, input logic mode0, input logic mode_rest,
                              input logic relu0, input int gap_max);
        logic [VW-1:0] d;
        int            v;
        for (int i = 0; i < FH*FW; i++) begin
            d = rand_vec();
            v = fv[i];
            d[DW-1:0] = v[DW-1:0];
            send_px(d, sof0 && (i == 0), (i == 0) ? mode0 : mode_rest,
                    (i == 0) ? relu0 : 1'($urandom));
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
            #0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk(1'b0, "drain_timeout", VW'(exp_q.size()), '0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input string nm);
        drain();
        chk(obs_v.size() == 4, {nm, "_count"}, VW'(obs_v.size()), VW'(4));
        for (int i = 0; i < 4 && i < obs_v.size(); i++) begin
            chk(obs_v[i] == ev[i], {nm, "_value"}, VW'(obs_v[i]), VW'(ev[i]));
            chk(obs_l[i] == (i == 3), {nm, "_last"}, VW'(obs_l[i]), VW'(i == 3));
        end
        obs_v.delete();
        obs_l.delete();
    endtask

    task automatic seq_fv();
        for (int i = 0; i < FH*FW; i++) fv[i] = i + 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin
        logic [VW-1:0] d;
        int            len;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk(out_valid === 1'b0, "rst_out_valid", VW'(out_valid), '0);
        chk(out_last === 1'b0, "rst_out_last", VW'(out_last), '0);
        chk(frame_err === 1'b0, "rst_frame_err", VW'(frame_err), '0);
        chk(out_data === '0, "rst_out_data", out_data, '0);
        chk(in_ready === 1'b1, "rst_in_ready", VW'(in_ready), VW'(1));
        @(posedge clk);
        #1;

        // Max pooling of 1..16.
        seq_fv();
        ev = '{6, 8, 14, 16};
        send_frame(1'b1, 1'b0, 1'b0, 1'b1, 0);
        check_obs("max_seq");

        // Mode changes mid-frame are ignored.
        send_frame(1'b1, 1'b0, 1'b1, 1'b1, 1);
        check_obs("latched_max");
        if (AVG_BUILT) ev = '{3, 5, 11, 13};
        else ev = '{6, 8, 14, 16};
        send_frame(1'b1, 1'b1, 1'b0, 1'b1, 1);
        check_obs("latched_avg");

        // Frame without in_sof keeps the previously latched mode.
        send_frame(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_obs("no_sof_keeps_mode");

        // Negative window, relu off then on.
        seq_fv();
        fv[0] = -3; fv[1] = -2; fv[4] = -1; fv[5] = -1;
        if (AVG_BUILT) ev = '{-2, 5, 11, 13};
        else ev = '{-1, 8, 14, 16};
        send_frame(1'b1, 1'b1, 1'b1, 1'b0, 0);
        check_obs("neg_relu_off");
        ev[0] = 0;
        send_frame(1'b1, 1'b1, 1'b1, 1'b1, 0);
        check_obs("neg_relu_on");

        // Output stall for 5 cycles.
        seq_fv();
        ev = '{6, 8, 14, 16};
        rdy_mode = 2;
        @(posedge clk);
        #1;
        fork
            begin
                int w = 0;
                while (!out_valid && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                chk(out_valid === 1'b1, "stall_valid_seen", VW'(out_valid), VW'(1));
                repeat (5) begin
                    @(negedge clk);
                    chk(in_ready === 1'b0, "stall_in_ready", VW'(in_ready), '0);
                    chk(out_valid === 1'b1, "stall_out_valid", VW'(out_valid), VW'(1));
                end
                rdy_mode = 0;
            end
            send_frame(1'b1, 1'b0, 1'b0, 1'b1, 0);
        join
        check_obs("stall");

        // in_sof at pixel (1,2) restarts the frame.
        for (int i = 0; i < 6; i++) begin
            d = rand_vec();
            d[DW-1:0] = DW'(100 + i);
            send_px(d, i == 0, 1'b0, 1'b1);
        end
        drain();
        chk(obs_v.size() == 1, "pre_restart_count", VW'(obs_v.size()), VW'(1));
        if (obs_v.size() > 0) chk(obs_v[0] == 105, "pre_restart_value", VW'(obs_v[0]), VW'(105));
        chk(frame_err === 1'b0, "pre_restart_err", VW'(frame_err), '0);
        obs_v.delete();
        obs_l.delete();
        send_frame(1'b1, 1'b0, 1'b0, 1'b1, 0);
        chk(frame_err === 1'b1, "restart_err", VW'(frame_err), VW'(1));
        check_obs("restart");

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 5; i++) send_px(rand_vec(), i == 0, 1'b0, 1'b1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send_frame(1'b1, 1'b0, 1'b0, 1'b1, 0);
        chk(frame_err === 1'b0, "after_reset_err", VW'(frame_err), '0);
        check_obs("after_reset");

        // Randomized frames with back-pressure and occasional aborted frames.
        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                len = $urandom_range(1, 10);
                for (int j = 0; j < len; j++)
                    send_px(rand_vec(), j == 0, 1'($urandom), 1'($urandom));
            end
            for (int i = 0; i < FH*FW; i++) fv[i] = int'($urandom_range(0, 400)) - 200;
            send_frame($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 1'($urandom), 2);
        end
        drain();
        rdy_mode = 0;
        obs_v.delete();
        obs_l.delete();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
